// File: rtl/dft_wb_stream_adapter_pkg.sv
// rtl/dft_wb_stream_adapter_pkg.sv - register map, STATUS bit positions and FSM encoding
// Contents:
//   REG_*     word index of each Wishbone register (wb_adr_i[2:0])
//   CTRL_*    CTRL bit positions
//   ST_*      STATUS bit positions
//   state_e   frame sequencer states
package dft_wb_stream_adapter_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DIN    = 3'd2;
  localparam logic [2:0] REG_DOUT   = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_IE    = 2;

  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_IN_FULL   = 2;
  localparam int ST_OUT_EMPTY = 3;
  localparam int ST_BAD_START = 4;
  localparam int ST_OVERRUN   = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE   = 3'd1,
    S_FEED    = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4
  } state_e;

endpackage

// File: rtl/dft_wb_stream_adapter_if.sv
// rtl/dft_wb_stream_adapter_if.sv - Wishbone classic single-beat bus bundle
// Signals (directions as seen from the slave):
//   wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_cyc_i/wb_stb_i  request
//   wb_dat_o/wb_ack_o/wb_err_o                            response
// Modports: slave (the adapter), master (bus driver).
interface dft_wb_stream_adapter_if #(
  parameter int AW = 30
);
  logic [AW-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/dft_sample_buf.sv
// rtl/dft_sample_buf.sv - N_PTS x 32 sample buffer, one- or two-word write and read
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 empty the buffer (pointers to 0)
//   wr_en, wr_two       push wr_data0 (and wr_data1 when wr_two)
//   rd_en, rd_two       pop one word (two when rd_two)
//   rd_data0/1          words at the read pointer and the one after it
//   count, full, empty  occupancy
module dft_sample_buf #(
  parameter  int N_PTS = 64,
  localparam int IW    = $clog2(N_PTS),
  localparam int PW    = IW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic          wr_two,
  input  logic [31:0]   wr_data0,
  input  logic [31:0]   wr_data1,
  input  logic          rd_en,
  input  logic          rd_two,
  output logic [31:0]   rd_data0,
  output logic [31:0]   rd_data1,
  output logic [PW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem [N_PTS];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] wr_idx1;
  logic [IW-1:0] rd_idx1;

  // Pointers carry one extra bit so full and empty stay distinct; the
  // difference is the occupancy without a separate counter.
  assign wr_idx1  = wr_ptr[IW-1:0] + IW'(1);
  assign rd_idx1  = rd_ptr[IW-1:0] + IW'(1);
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == PW'(N_PTS));
  assign empty    = (count == '0);
  assign rd_data0 = mem[rd_ptr[IW-1:0]];
  assign rd_data1 = mem[rd_idx1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (wr_two ? PW'(2) : PW'(1));
      if (rd_en) rd_ptr <= rd_ptr + (rd_two ? PW'(2) : PW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      mem[wr_ptr[IW-1:0]] <= wr_data0;
      if (wr_two) mem[wr_idx1] <= wr_data1;
    end
  end

endmodule

// File: rtl/dft_wb_stream_adapter.sv
// rtl/dft_wb_stream_adapter.sv - Wishbone slave feeding a frame to a streaming DFT core and capturing its result
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   wb                            Wishbone slave (registers CTRL/STATUS/DIN/DOUT/COUNT)
//   int_o                         level interrupt, STATUS.done & CTRL.ie
//   dft_next_o, dft_x0_o..x3_o    frame start pulse and two complex samples per cycle to the core
//   dft_next_out_i, dft_y0_i..y3_i output frame start and transformed samples from the core
module dft_wb_stream_adapter
  import dft_wb_stream_adapter_pkg::*;
#(
  parameter int AW    = 30,
  parameter int DW    = 32,
  parameter int N_PTS = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  dft_wb_stream_adapter_if.slave        wb,
  output logic                          int_o,
  output logic                          dft_next_o,
  output logic [15:0]                   dft_x0_o,
  output logic [15:0]                   dft_x1_o,
  output logic [15:0]                   dft_x2_o,
  output logic [15:0]                   dft_x3_o,
  input  logic                          dft_next_out_i,
  input  logic [15:0]                   dft_y0_i,
  input  logic [15:0]                   dft_y1_i,
  input  logic [15:0]                   dft_y2_i,
  input  logic [15:0]                   dft_y3_i
);

  localparam int PW     = $clog2(N_PTS) + 1;
  localparam int HALF   = N_PTS / 2;
  localparam int ADR_HI = AW - 1;

  state_e        state, state_nxt;
  logic [PW-1:0] beat, beat_nxt;
  logic          ie, done, bad_start, overrun;
  logic          ack, err;
  logic [DW-1:0] dat, resp_dat, status_word;
  logic          resp_ok;

  logic [31:0]   ib_rd0, ib_rd1, ob_rd0;
  logic [PW-1:0] ib_count, ob_count;
  logic          in_full, out_empty;
  logic [31:0]   unused_ob_rd1;
  logic          unused_ob_full, unused_ib_empty, unused_adr;

  logic [2:0] idx;
  logic       req, sel_ok, ctrl_wr, soft_clr, start_req, busy, start_go, start_bad;
  logic       din_push, dout_pop, status_rd, feed, capture, last_beat, cap_enter;

  assign unused_adr = ^wb.wb_adr_i[ADR_HI:3];

  assign idx       = wb.wb_adr_i[2:0];
  assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack & ~err;
  assign sel_ok    = (wb.wb_sel_i == 4'hF);
  assign busy      = (state != S_IDLE);
  assign feed      = (state == S_FEED);
  assign capture   = (state == S_CAPTURE);
  assign last_beat = (beat == PW'(HALF - 1));
  assign cap_enter = (state == S_WAIT) & dft_next_out_i;

  assign ctrl_wr   = req & wb.wb_we_i & sel_ok & (idx == REG_CTRL);
  assign soft_clr  = ctrl_wr & wb.wb_dat_i[CTRL_CLEAR];
  assign start_req = ctrl_wr & wb.wb_dat_i[CTRL_START] & ~wb.wb_dat_i[CTRL_CLEAR];
  assign start_go  = start_req & ~busy & in_full;
  assign start_bad = start_req & ~busy & ~in_full;
  assign status_rd = req & ~wb.wb_we_i & (idx == REG_STATUS);
  assign din_push  = req & resp_ok & wb.wb_we_i & (idx == REG_DIN);
  assign dout_pop  = req & resp_ok & ~wb.wb_we_i & (idx == REG_DOUT);

  always_comb begin
    status_word               = '0;
    status_word[ST_BUSY]      = busy;
    status_word[ST_DONE]      = done;
    status_word[ST_IN_FULL]   = in_full;
    status_word[ST_OUT_EMPTY] = out_empty;
    status_word[ST_BAD_START] = bad_start;
    status_word[ST_OVERRUN]   = overrun;
  end

  // Response decode; read data is forced to zero on writes and errors.
  always_comb begin
    resp_ok  = 1'b0;
    resp_dat = '0;
    case (idx)
      REG_CTRL: begin
        resp_ok           = wb.wb_we_i ? sel_ok : 1'b1;
        resp_dat[CTRL_IE] = ie;
      end
      REG_STATUS: begin
        resp_ok  = ~wb.wb_we_i;
        resp_dat = status_word;
      end
      REG_DIN:   resp_ok = wb.wb_we_i & sel_ok & ~in_full & ~busy;
      REG_DOUT: begin
        resp_ok  = ~wb.wb_we_i & ~out_empty & ~capture;
        resp_dat = ob_rd0;
      end
      REG_COUNT: begin
        resp_ok  = ~wb.wb_we_i;
        resp_dat = {16'(ob_count), 16'(ib_count)};
      end
      default: resp_ok = 1'b0;
    endcase
    if (!resp_ok || wb.wb_we_i) resp_dat = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack <= 1'b0;
      err <= 1'b0;
      dat <= '0;
    end else begin
      ack <= req & resp_ok;
      err <= req & ~resp_ok;
      dat <= req ? resp_dat : '0;
    end
  end

  assign wb.wb_ack_o = ack;
  assign wb.wb_err_o = err;
  assign wb.wb_dat_o = dat;

  // A CTRL write carrying the clear bit leaves ie untouched so software can
  // recover the datapath without re-arming the interrupt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ie        <= 1'b0;
      done      <= 1'b0;
      bad_start <= 1'b0;
      overrun   <= 1'b0;
    end else if (soft_clr) begin
      done      <= 1'b0;
      bad_start <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= wb.wb_dat_i[CTRL_IE];
      if (status_rd) begin
        done      <= 1'b0;
        bad_start <= 1'b0;
        overrun   <= 1'b0;
      end
      if (start_bad) bad_start <= 1'b1;
      if (capture && last_beat) done <= 1'b1;
      if (dft_next_out_i && state != S_WAIT) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // beat is zero on entry to FEED and CAPTURE and counts their HALF cycles.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      S_IDLE:  if (start_go) state_nxt = S_PULSE;
      S_PULSE: begin
        state_nxt = S_FEED;
        beat_nxt  = '0;
      end
      S_FEED: begin
        if (last_beat) begin
          state_nxt = S_WAIT;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat + PW'(1);
        end
      end
      S_WAIT: if (dft_next_out_i) state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (last_beat) begin
          state_nxt = S_IDLE;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat + PW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (soft_clr) begin
      state_nxt = S_IDLE;
      beat_nxt  = '0;
    end
  end

  assign dft_next_o = (state == S_PULSE);
  assign dft_x0_o   = feed ? ib_rd0[15:0]  : 16'h0;
  assign dft_x1_o   = feed ? ib_rd0[31:16] : 16'h0;
  assign dft_x2_o   = feed ? ib_rd1[15:0]  : 16'h0;
  assign dft_x3_o   = feed ? ib_rd1[31:16] : 16'h0;
  assign int_o      = done & ie;

  dft_sample_buf #(.N_PTS(N_PTS)) u_in_buf (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .clr      (soft_clr),
    .wr_en    (din_push),
    .wr_two   (1'b0),
    .wr_data0 (wb.wb_dat_i),
    .wr_data1 (32'h0),
    .rd_en    (feed),
    .rd_two   (1'b1),
    .rd_data0 (ib_rd0),
    .rd_data1 (ib_rd1),
    .count    (ib_count),
    .full     (in_full),
    .empty    (unused_ib_empty)
  );

  dft_sample_buf #(.N_PTS(N_PTS)) u_out_buf (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .clr      (soft_clr | cap_enter),
    .wr_en    (capture),
    .wr_two   (1'b1),
    .wr_data0 ({dft_y1_i, dft_y0_i}),
    .wr_data1 ({dft_y3_i, dft_y2_i}),
    .rd_en    (dout_pop),
    .rd_two   (1'b0),
    .rd_data0 (ob_rd0),
    .rd_data1 (unused_ob_rd1),
    .count    (ob_count),
    .full     (unused_ob_full),
    .empty    (out_empty)
  );

endmodule

// File: tb/tb_dft_wb_stream_adapter.sv
// tb/tb_dft_wb_stream_adapter.sv - directed self-checking bench for dft_wb_stream_adapter
module tb_dft_wb_stream_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        int_o, dft_next_o, next_out;
  logic [15:0] x0, x1, x2, x3, y0, y1, y2, y3;
  int          checks = 0;
  int          fails = 0;
  int          pulse_cnt = 0;

  always #5 clk = ~clk;

  dft_wb_stream_adapter_if #(.AW(30)) wb_bus ();

  dft_wb_stream_adapter #(.AW(30), .DW(32), .N_PTS(64)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .wb             (wb_bus),
    .int_o          (int_o),
    .dft_next_o     (dft_next_o),
    .dft_x0_o       (x0),
    .dft_x1_o       (x1),
    .dft_x2_o       (x2),
    .dft_x3_o       (x3),
    .dft_next_out_i (next_out),
    .dft_y0_i       (y0),
    .dft_y1_i       (y1),
    .dft_y2_i       (y2),
    .dft_y3_i       (y3)
  );

  always @(negedge clk) if (dft_next_o === 1'b1) pulse_cnt++;

  task automatic wb_xfer(input logic [2:0] idx, input logic we, input logic [31:0] wdata,
                         input logic [3:0] sel, output logic [31:0] rdata,
                         output logic ack, output logic err);
    @(negedge clk);
    wb_bus.wb_adr_i = {27'($urandom), idx};
    wb_bus.wb_we_i  = we;
    wb_bus.wb_dat_i = wdata;
    wb_bus.wb_sel_i = sel;
    wb_bus.wb_cyc_i = 1'b1;
    wb_bus.wb_stb_i = 1'b1;
    @(negedge clk);
    rdata = wb_bus.wb_dat_o;
    ack   = wb_bus.wb_ack_o;
    err   = wb_bus.wb_err_o;
    wb_bus.wb_cyc_i = 1'b0;
    wb_bus.wb_stb_i = 1'b0;
    wb_bus.wb_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic a, e;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_bus.wb_ack_o, wb_bus.wb_err_o, int_o, dft_next_o} !== 4'b0 ||
        wb_bus.wb_dat_o !== 32'h0 || {x0, x1, x2, x3} !== 64'h0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b err=%b int=%b next=%b dat=%h x=%h, required all 0",
               wb_bus.wb_ack_o, wb_bus.wb_err_o, int_o, dft_next_o, wb_bus.wb_dat_o, {x0, x1, x2, x3});
    end
    rst_n = 1'b1;
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b1 || e !== 1'b0 || rd !== 32'h8) begin
      fails++; $display("FAIL reset_status: ack=%b err=%b data=%h, required ack=1 data=00000008", a, e, rd);
    end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL reset_count: ack=%b data=%h, required ack=1 data=00000000", a, rd);
    end
    wb_xfer(3'd0, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL reset_ctrl: ack=%b data=%h, required ack=1 data=00000000", a, rd);
    end
  endtask

  task automatic test_load_and_feed();
    logic [31:0] rd;
    logic a, e;
    int bad = 0;
    int p0;
    for (int i = 1; i <= 64; i++) begin
      wb_xfer(3'd2, 1'b1, 32'(i), 4'hF, rd, a, e);
      if (a !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL din_load: %0d writes not acked, required 0", bad); end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h40) begin fails++; $display("FAIL count_full: data=%h, required 00000040", rd); end
    wb_xfer(3'd0, 1'b1, 32'h4, 4'hF, rd, a, e);
    p0 = pulse_cnt;
    wb_xfer(3'd0, 1'b1, 32'h5, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b1 || dft_next_o !== 1'b1) begin
      fails++; $display("FAIL start_pulse: ack=%b next=%b, required 1 1", a, dft_next_o);
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if ({x0, x1, x2, x3} !== {16'(2 * k + 1), 16'h0, 16'(2 * k + 2), 16'h0}) begin
        fails++; $display("FAIL feed_beat %0d: x=%h %h %h %h, required %h 0000 %h 0000",
                          k, x0, x1, x2, x3, 16'(2 * k + 1), 16'(2 * k + 2));
      end
    end
    @(negedge clk);
    checks++;
    if ({x0, x1, x2, x3} !== 64'h0) begin fails++; $display("FAIL feed_end: x=%h, required 0", {x0, x1, x2, x3}); end
    checks++;
    if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL pulse_count: %0d pulses, required 1", pulse_cnt - p0); end
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h9) begin fails++; $display("FAIL wait_status: data=%h, required 00000009", rd); end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL count_after_feed: data=%h, required 00000000", rd); end
  endtask

  task automatic test_capture();
    logic [31:0] rd;
    logic a, e;
    @(negedge clk);
    next_out = 1'b1;
    @(negedge clk);
    next_out = 1'b0;
    for (int j = 0; j < 32; j++) begin
      y0 = 16'(2 * j); y1 = 16'h0; y2 = 16'(2 * j + 1); y3 = 16'h0;
      @(negedge clk);
    end
    {y0, y1, y2, y3} = 64'h0;
    checks++;
    if (int_o !== 1'b1) begin fails++; $display("FAIL int_done: int=%b, required 1", int_o); end
    for (int j = 0; j < 64; j++) begin
      wb_xfer(3'd3, 1'b0, 32'h0, 4'hF, rd, a, e);
      checks++;
      if (a !== 1'b1 || rd !== 32'(j)) begin
        fails++; $display("FAIL dout_read %0d: ack=%b data=%h, required ack=1 data=%h", j, a, rd, 32'(j));
      end
    end
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'hA) begin fails++; $display("FAIL done_status: data=%h, required 0000000a", rd); end
    @(negedge clk);
    checks++;
    if (int_o !== 1'b0) begin fails++; $display("FAIL int_cleared: int=%b, required 0", int_o); end
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h8) begin fails++; $display("FAIL status_after_clear: data=%h, required 00000008", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic a, e;
    wb_xfer(3'd3, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b0 || e !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL dout_empty: ack=%b err=%b data=%h, required ack=0 err=1 data=0", a, e, rd);
    end
    wb_xfer(3'd5, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b0 || e !== 1'b1) begin fails++; $display("FAIL bad_index: ack=%b err=%b, required 0 1", a, e); end
    wb_xfer(3'd2, 1'b1, 32'h1234, 4'h3, rd, a, e);
    checks++;
    if (a !== 1'b0 || e !== 1'b1) begin fails++; $display("FAIL partial_sel: ack=%b err=%b, required 0 1", a, e); end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL count_no_push: data=%h, required 00000000", rd); end
  endtask

  task automatic test_bad_start();
    logic [31:0] rd;
    logic a, e;
    int p0;
    for (int i = 0; i < 10; i++) wb_xfer(3'd2, 1'b1, 32'h100 + 32'(i), 4'hF, rd, a, e);
    p0 = pulse_cnt;
    wb_xfer(3'd0, 1'b1, 32'h1, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b1 || e !== 1'b0) begin fails++; $display("FAIL bad_start_ack: ack=%b err=%b, required 1 0", a, e); end
    repeat (2) @(negedge clk);
    checks++;
    if (pulse_cnt !== p0 || dft_next_o !== 1'b0) begin
      fails++; $display("FAIL bad_start_pulse: %0d pulses, required 0", pulse_cnt - p0);
    end
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h18) begin fails++; $display("FAIL bad_start_status: data=%h, required 00000018", rd); end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'hA) begin fails++; $display("FAIL count_ten: data=%h, required 0000000a", rd); end
    for (int i = 10; i < 64; i++) wb_xfer(3'd2, 1'b1, 32'h100 + 32'(i), 4'hF, rd, a, e);
    wb_xfer(3'd2, 1'b1, 32'hDEAD, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b0 || e !== 1'b1) begin fails++; $display("FAIL din_overfill: ack=%b err=%b, required 0 1", a, e); end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h40) begin fails++; $display("FAIL count_capped: data=%h, required 00000040", rd); end
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'hC) begin fails++; $display("FAIL full_status: data=%h, required 0000000c", rd); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    logic a, e;
    int p0;
    p0 = pulse_cnt;
    wb_xfer(3'd0, 1'b1, 32'h5, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b1 || dft_next_o !== 1'b1) begin
      fails++; $display("FAIL start2_pulse: ack=%b next=%b, required 1 1", a, dft_next_o);
    end
    @(negedge clk);
    checks++;
    if ({x0, x1, x2, x3} !== 64'h0100_0000_0101_0000) begin
      fails++; $display("FAIL feed2_first: x=%h %h %h %h, required 0100 0000 0101 0000", x0, x1, x2, x3);
    end
    wb_xfer(3'd0, 1'b1, 32'h5, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b1 || e !== 1'b0) begin fails++; $display("FAIL busy_start_ack: ack=%b err=%b, required 1 0", a, e); end
    next_out = 1'b1;
    @(negedge clk);
    next_out = 1'b0;
    repeat (35) @(negedge clk);
    checks++;
    if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL busy_start_pulse: %0d pulses, required 1", pulse_cnt - p0); end
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h29) begin fails++; $display("FAIL overrun_status: data=%h, required 00000029", rd); end
    repeat (5) @(negedge clk);
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h9) begin fails++; $display("FAIL still_waiting: data=%h, required 00000009", rd); end
  endtask

  task automatic test_reset_mid_capture();
    logic [31:0] rd;
    logic a, e;
    next_out = 1'b1;
    @(negedge clk);
    next_out = 1'b0;
    {y0, y1, y2, y3} = 64'h1111_2222_3333_4444;
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h1) begin fails++; $display("FAIL capture_status: data=%h, required 00000001", rd); end
    wb_xfer(3'd3, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b0 || e !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL dout_in_capture: ack=%b err=%b data=%h, required 0 1 0", a, e, rd);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_bus.wb_ack_o, wb_bus.wb_err_o, int_o, dft_next_o} !== 4'b0 ||
        wb_bus.wb_dat_o !== 32'h0 || {x0, x1, x2, x3} !== 64'h0) begin
      fails++; $display("FAIL async_reset_outputs: ack=%b err=%b int=%b next=%b, required all 0",
                        wb_bus.wb_ack_o, wb_bus.wb_err_o, int_o, dft_next_o);
    end
    {y0, y1, y2, y3} = 64'h0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h8) begin fails++; $display("FAIL status_after_reset: data=%h, required 00000008", rd); end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL count_after_reset: data=%h, required 00000000", rd); end
    wb_xfer(3'd0, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL ie_after_reset: data=%h, required 00000000", rd); end
  endtask

  task automatic test_soft_clear();
    logic [31:0] rd;
    logic a, e;
    for (int i = 0; i < 64; i++) wb_xfer(3'd2, 1'b1, 32'h200 + 32'(i), 4'hF, rd, a, e);
    wb_xfer(3'd0, 1'b1, 32'h5, 4'hF, rd, a, e);
    repeat (3) @(negedge clk);
    wb_xfer(3'd0, 1'b1, 32'h2, 4'hF, rd, a, e);
    checks++;
    if (a !== 1'b1 || dft_next_o !== 1'b0 || {x0, x1, x2, x3} !== 64'h0) begin
      fails++; $display("FAIL soft_clear_outputs: ack=%b next=%b x=%h, required ack=1 next=0 x=0",
                        a, dft_next_o, {x0, x1, x2, x3});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({x0, x1, x2, x3} !== 64'h0 || int_o !== 1'b0) begin
      fails++; $display("FAIL soft_clear_idle: x=%h int=%b, required 0 0", {x0, x1, x2, x3}, int_o);
    end
    wb_xfer(3'd1, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h8) begin fails++; $display("FAIL soft_clear_status: data=%h, required 00000008", rd); end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL soft_clear_count: data=%h, required 00000000", rd); end
    wb_xfer(3'd0, 1'b0, 32'h0, 4'hF, rd, a, e);
    checks++;
    if (rd !== 32'h4) begin fails++; $display("FAIL soft_clear_ie: data=%h, required 00000004", rd); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    next_out        = 1'b0;
    {y0, y1, y2, y3} = 64'h0;
    wb_bus.wb_adr_i = '0;
    wb_bus.wb_dat_i = '0;
    wb_bus.wb_sel_i = '0;
    wb_bus.wb_we_i  = 1'b0;
    wb_bus.wb_cyc_i = 1'b0;
    wb_bus.wb_stb_i = 1'b0;
    test_reset();
    test_load_and_feed();
    test_capture();
    test_errors();
    test_bad_start();
    test_overrun();
    test_reset_mid_capture();
    test_soft_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
